// File: rtl/wb_commit.sv
// Writeback/commit stage: holds one instruction from MEM, resolves its exception,
// drives the CSR/GPR write ports and redirects the front end on exception or ERTN.
module wb_commit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ms_valid,
   output logic        wb_allowin,
   input  logic [31:0] ms_pc,
   input  logic [4:0]  ms_exc,
   input  logic [31:0] ms_vaddr,
   input  logic        ms_is_ertn,
   input  logic        ms_csr_we,
   input  logic [13:0] ms_csr_addr,
   input  logic [31:0] ms_csr_wdata,
   input  logic [31:0] ms_csr_wmask,
   input  logic        ms_rf_we,
   input  logic [4:0]  ms_rf_waddr,
   input  logic [31:0] ms_rf_wdata,
   input  logic        interruption,
   input  logic [31:0] exception_entry,
   input  logic [31:0] exception_return_entry,
   output logic        csr_we,
   output logic [13:0] csr_addr,
   output logic [31:0] csr_wdata,
   output logic [31:0] csr_wmask,
   output logic        ertn_flush,
   output logic        wb_exception,
   output logic [5:0]  wb_ecode,
   output logic [8:0]  wb_esubcode,
   output logic [31:0] wb_vaddr,
   output logic [31:0] wb_pc,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        flush,
   output logic [31:0] flush_target,
   output logic [31:0] retire_cnt
);

   typedef enum logic {RUN, FLUSH} state_t;

   state_t      state_q, state_d;
   logic        ws_valid;
   logic [31:0] ws_pc;
   logic [4:0]  ws_exc;
   logic [31:0] ws_vaddr;
   logic        ws_is_ertn;
   logic        ws_csr_we;
   logic [13:0] ws_csr_addr;
   logic [31:0] ws_csr_wdata;
   logic [31:0] ws_csr_wmask;
   logic        ws_rf_we;
   logic [4:0]  ws_rf_waddr;
   logic [31:0] ws_rf_wdata;
   logic [31:0] flush_target_q;
   logic [31:0] retire_q;
   logic        exc_hit;
   logic        commit_flush;
   logic        load;

   // Interrupts are only taken on a committing instruction, ahead of all synchronous faults.
   always_comb begin
      wb_ecode = 6'h00;
      wb_vaddr = 32'h0;
      if (interruption) begin
         wb_ecode = 6'h00;
      end else if (ws_exc[0]) begin
         wb_ecode = 6'h08;
         wb_vaddr = ws_pc;
      end else if (ws_exc[1]) begin
         wb_ecode = 6'h0D;
      end else if (ws_exc[2]) begin
         wb_ecode = 6'h0B;
      end else if (ws_exc[3]) begin
         wb_ecode = 6'h0C;
      end else if (ws_exc[4]) begin
         wb_ecode = 6'h09;
         wb_vaddr = ws_vaddr;
      end
   end

   assign exc_hit      = ws_valid && (interruption || (|ws_exc));
   assign commit_flush = exc_hit || (ws_valid && ws_is_ertn);

   always_comb begin
      state_d    = state_q;
      wb_allowin = 1'b0;
      flush      = 1'b0;
      case (state_q)
         RUN: begin
            wb_allowin = 1'b1;
            if (commit_flush) state_d = FLUSH;
         end
         FLUSH: begin
            flush   = 1'b1;
            state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   // A redirecting commit kills whatever MEM offers in the same cycle.
   assign load = ms_valid && wb_allowin && !commit_flush;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= RUN;
         ws_valid       <= 1'b0;
         flush_target_q <= 32'h0;
         retire_q       <= 32'h0;
      end else begin
         state_q  <= state_d;
         ws_valid <= load;
         if (commit_flush)
            flush_target_q <= exc_hit ? exception_entry : exception_return_entry;
         if (ws_valid && !exc_hit)
            retire_q <= retire_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (load) begin
         ws_pc        <= ms_pc;
         ws_exc       <= ms_exc;
         ws_vaddr     <= ms_vaddr;
         ws_is_ertn   <= ms_is_ertn;
         ws_csr_we    <= ms_csr_we;
         ws_csr_addr  <= ms_csr_addr;
         ws_csr_wdata <= ms_csr_wdata;
         ws_csr_wmask <= ms_csr_wmask;
         ws_rf_we     <= ms_rf_we;
         ws_rf_waddr  <= ms_rf_waddr;
         ws_rf_wdata  <= ms_rf_wdata;
      end
   end

   assign wb_exception = exc_hit;
   assign wb_esubcode  = 9'd0;
   assign wb_pc        = ws_pc;
   assign ertn_flush   = ws_valid && ws_is_ertn && !exc_hit;
   assign csr_we       = ws_valid && ws_csr_we && !exc_hit;
   assign csr_addr     = ws_csr_addr;
   assign csr_wdata    = ws_csr_wdata;
   assign csr_wmask    = ws_csr_wmask;
   assign rf_we        = ws_valid && ws_rf_we && !exc_hit;
   assign rf_waddr     = ws_rf_waddr;
   assign rf_wdata     = ws_rf_wdata;
   assign flush_target = flush_target_q;
   assign retire_cnt   = retire_q;

endmodule

// File: doc/wb_commit.md
WB_COMMIT -- requirements
Module: wb_commit

Interface
Single clock clk; reset rst_n is synchronous and active-low.
REQ-001 SHALL have ports (name direction width meaning):
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- ms_valid  in  1  MEM-stage instruction valid
- wb_allowin  out  1  WB accepts MEM instruction this cycle
- ms_pc  in  32  instruction PC
- ms_exc  in  5  exception flags: [0] ADEF, [1] INE, [2] SYS, [3] BRK, [4] ALE
- ms_vaddr  in  32  faulting data address (ALE)
- ms_is_ertn  in  1  instruction is ERTN
- ms_csr_we  in  1  CSR write request
- ms_csr_addr  in  14  CSR address
- ms_csr_wdata  in  32  CSR write data
- ms_csr_wmask  in  32  CSR write mask
- ms_rf_we  in  1  GPR write request
- ms_rf_waddr  in  5  GPR index
- ms_rf_wdata  in  32  GPR data
- interruption  in  1  pending enabled interrupt from CSR block
- exception_entry  in  32  exception handler address
- exception_return_entry  in  32  ERTN return address
- csr_we, csr_addr, csr_wdata, csr_wmask  out  1/14/32/32  CSR write port
- ertn_flush  out  1  ERTN commit strobe
- wb_exception  out  1  exception commit strobe
- wb_ecode  out  6  exception code
- wb_esubcode  out  9  exception subcode
- wb_vaddr  out  32  bad virtual address
- wb_pc  out  32  PC of committing instruction
- rf_we, rf_waddr, rf_wdata  out  1/5/32  GPR write port
- flush  out  1  pipeline flush pulse
- flush_target  out  32  redirect PC
- retire_cnt  out  32  retired-instruction count

Function
REQ-002 SHALL hold one instruction in a WB register (ws_valid plus all ms_* fields), loaded when ms_valid && wb_allowin.
REQ-003 SHALL implement FSM RUN/FLUSH; wb_allowin = 1 in RUN, 0 in FLUSH.
REQ-004 SHALL commit the held instruction in the cycle ws_valid=1; ws_valid clears next cycle unless a new load occurs.
REQ-005 SHALL select exceptions by priority INT > ADEF > INE > SYS > BRK > ALE; INT applies when interruption=1 during commit.
REQ-006 SHALL encode ecode/esubcode: INT 0x00/0, ADEF 0x08/0, INE 0x0D/0, SYS 0x0B/0, BRK 0x0C/0, ALE 0x09/0.
REQ-007 SHALL drive wb_vaddr = ws_vaddr for ALE, ws_pc for ADEF, 0 otherwise; wb_pc = ws_pc whenever ws_valid.
REQ-008 SHALL pulse wb_exception for one cycle on a committing excepted instruction, and suppress rf_we, csr_we and ertn_flush for it.
REQ-009 SHALL pulse ertn_flush on ERTN commit with no exception.
REQ-010 SHALL drive csr_we = ws_valid && ws_csr_we && !exception and rf_we likewise; data/address pass through unmodified.
REQ-011 On exception or ERTN commit, SHALL latch flush_target (exception_entry or exception_return_entry at that cycle), enter FLUSH, and discard any MEM instruction offered in that cycle.
REQ-012 In FLUSH: flush=1 for exactly one cycle, no load, then return to RUN.
REQ-013 flush_target SHALL hold its value until the next exception/ERTN commit.
REQ-014 retire_cnt SHALL increment by 1 per non-excepted commit (ERTN included), wrapping 0xFFFFFFFF -> 0.
REQ-015 SHALL assert no CSR/RF/exception strobe when ws_valid=0, even if interruption=1.

Reset
REQ-016 On rst_n=0 at a clk edge: ws_valid=0, state RUN, flush=0, flush_target=0, retire_cnt=0; all strobes 0 the following cycle. Reset overrides an in-flight commit or FLUSH.

Verification
REQ-017 ADD with rf_we, waddr 5, wdata 0x1234 -> rf_we=1 one cycle, retire_cnt +1, no flush.
REQ-018 SYS at pc 0x1C000100, exception_entry 0x1C008000 -> wb_exception=1, ecode 0x0B, wb_pc 0x1C000100; next cycle flush=1, flush_target 0x1C008000; wb_allowin=0 that cycle; retire_cnt unchanged.
REQ-019 ALE plus csr_we, vaddr 0x3 -> ecode 0x09, wb_vaddr 0x3, csr_we=0.
REQ-020 interruption=1 with ADEF instruction -> ecode 0x00 (INT wins); rf_we=0.
REQ-021 ERTN, exception_return_entry 0x1C000200 -> ertn_flush=1, then flush=1 with target 0x1C000200; back-to-back MEM instruction dropped.
REQ-022 retire_cnt preset to 0xFFFFFFFF via commits -> wraps to 0; rst_n low during FLUSH -> flush=0 next cycle.
